sb_rx_pkt_fifo: RTL and testbench

Receive-side sideband packet buffer. It sits between the sideband RX deserializer and the sideband message decoder, mirroring the TX FIFO on the transmit path. It assembles deserialized 64-bit words into packets: a header, plus a 64-bit data phase when the opcode carries data. Complete packets are stored and presented one at a time on a registered read port, with a credit-return pulse for every packet consumed.

---
 rtl/sb_rx_pkg.sv | 41 ++++
 rtl/sb_rx_pkt_fifo.sv | 139 +++++++++++++
 tb/tb_sb_rx_pkt_fifo.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sb_rx_pkg.sv
// ============================================================================
// Module      : sb_rx_pkg
// Description : Shared types, opcodes and data-phase decode for sideband RX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sb_rx_pkg;

    typedef enum logic [0:0] {
        ST_HDR  = 1'b0,
        ST_DATA = 1'b1
    } sb_state_e;

    localparam logic [4:0] OPC_DATA_00001 = 5'b00001;
    localparam logic [4:0] OPC_DATA_00011 = 5'b00011;
    localparam logic [4:0] OPC_DATA_00101 = 5'b00101;
    localparam logic [4:0] OPC_DATA_01001 = 5'b01001;
    localparam logic [4:0] OPC_DATA_01011 = 5'b01011;
    localparam logic [4:0] OPC_DATA_01101 = 5'b01101;
    localparam logic [4:0] OPC_DATA_10001 = 5'b10001;
    localparam logic [4:0] OPC_DATA_11000 = 5'b11000;
    localparam logic [4:0] OPC_DATA_11001 = 5'b11001;
    localparam logic [4:0] OPC_DATA_11011 = 5'b11011;

    // Shared with the TX-side message builder: opcode carries a 64-bit data phase.
    function automatic logic sb_has_data(input logic [4:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OPC_DATA_00001, OPC_DATA_00011, OPC_DATA_00101, OPC_DATA_01001,
            OPC_DATA_01011, OPC_DATA_01101, OPC_DATA_10001, OPC_DATA_11000,
            OPC_DATA_11001, OPC_DATA_11011: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sb_rx_pkt_fifo.sv
// ============================================================================
// Module      : sb_rx_pkt_fifo
// Description : Sideband RX packet assembler and packet FIFO with credit return.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_rx_pkt_fifo
    import sb_rx_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_deser_valid,
    input  logic [63:0]   i_deser_data,
    input  logic          i_flush,
    input  logic          i_read_enable,
    output logic [63:0]   o_hdr,
    output logic [63:0]   o_data,
    output logic          o_has_data,
    output logic          o_rd_valid,
    output logic          o_credit_ret,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_count,
    output logic          o_overflow
);

    localparam logic [AW:0] c_ptr_one = {{AW{1'b0}}, 1'b1};

    logic [63:0] hdr_mem_q  [DEPTH];
    logic [63:0] data_mem_q [DEPTH];
    logic        has_mem_q  [DEPTH];

    sb_state_e   state_q;
    logic [63:0] hdr_q;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [63:0] rd_hdr_q, rd_data_q;
    logic        rd_has_q, rd_valid_q, credit_q, overflow_q;

    logic        w_full, w_empty, w_commit, w_wr_en, w_rd_en;
    logic [63:0] w_ent_hdr, w_ent_data;
    logic        w_ent_has;

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A packet completes on a header-only word in ST_HDR or on any word in ST_DATA.
    assign w_commit = i_deser_valid && !i_flush &&
                      ((state_q == ST_DATA) || !sb_has_data(i_deser_data[4:0]));
    assign w_wr_en  = w_commit && !w_full;
    assign w_rd_en  = i_read_enable && !w_empty && !i_flush;

    assign w_ent_has  = (state_q == ST_DATA);
    assign w_ent_hdr  = w_ent_has ? hdr_q : i_deser_data;
    assign w_ent_data = w_ent_has ? i_deser_data : 64'd0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_wr_en) wr_ptr_d = wr_ptr_q + c_ptr_one;
            if (w_rd_en) rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            hdr_mem_q[wr_ptr_q[AW-1:0]]  <= w_ent_hdr;
            data_mem_q[wr_ptr_q[AW-1:0]] <= w_ent_data;
            has_mem_q[wr_ptr_q[AW-1:0]]  <= w_ent_has;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_HDR;
            hdr_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_hdr_q   <= '0;
            rd_data_q  <= '0;
            rd_has_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            credit_q <= rd_valid_q;
            if (i_flush) begin
                state_q    <= ST_HDR;
                hdr_q      <= '0;
                rd_valid_q <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                rd_valid_q <= w_rd_en;
                if (w_rd_en) begin
                    rd_hdr_q  <= hdr_mem_q[rd_ptr_q[AW-1:0]];
                    rd_data_q <= data_mem_q[rd_ptr_q[AW-1:0]];
                    rd_has_q  <= has_mem_q[rd_ptr_q[AW-1:0]];
                end
                if (w_commit && w_full) overflow_q <= 1'b1;
                if (i_deser_valid) begin
                    case (state_q)
                        ST_HDR: begin
                            if (sb_has_data(i_deser_data[4:0])) begin
                                hdr_q   <= i_deser_data;
                                state_q <= ST_DATA;
                            end
                        end
                        ST_DATA: state_q <= ST_HDR;
                        default: state_q <= ST_HDR;
                    endcase
                end
            end
        end
    end

    assign o_hdr        = rd_hdr_q;
    assign o_data       = rd_data_q;
    assign o_has_data   = rd_has_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_credit_ret = credit_q;
    assign o_empty      = w_empty;
    assign o_full       = w_full;
    assign o_count      = wr_ptr_q - rd_ptr_q;
    assign o_overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sb_rx_pkt_fifo.sv
// ============================================================================
// Module      : tb_sb_rx_pkt_fifo
// Description : Self-checking bench for sb_rx_pkt_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sb_rx_pkt_fifo;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam logic [4:0] DATA_OPS [10] = '{5'b00001, 5'b00011, 5'b00101, 5'b01001,
                                            5'b01011, 5'b01101, 5'b10001, 5'b11000,
                                            5'b11001, 5'b11011};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          deser_valid, flush, read_enable;
    logic [63:0]   deser_data;
    logic [63:0]   hdr, data;
    logic          has_data, rd_valid, credit_ret, empty, full, overflow;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    sb_rx_pkt_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_deser_valid(deser_valid), .i_deser_data(deser_data),
        .i_flush(flush), .i_read_enable(read_enable),
        .o_hdr(hdr), .o_data(data), .o_has_data(has_data),
        .o_rd_valid(rd_valid), .o_credit_ret(credit_ret),
        .o_empty(empty), .o_full(full), .o_count(count), .o_overflow(overflow)
    );

    typedef struct {
        logic [63:0] h;
        logic [63:0] d;
        logic        hd;
    } pkt_t;

    pkt_t        mq[$];
    bit          m_pend;
    logic [63:0] m_phdr, m_hdr, m_data;
    logic        m_has, m_rv, m_cr, m_ovf;
    int          errors = 0;
    int          checks = 0;

    function automatic bit is_data_op(input logic [4:0] op);
        foreach (DATA_OPS[k]) if (DATA_OPS[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = 0; m_phdr = '0; m_hdr = '0; m_data = '0;
        m_has = 0; m_rv = 0; m_cr = 0; m_ovf = 0;
    endtask

    task automatic compare_all();
        chk("hdr",        hdr,        m_hdr);
        chk("data",       data,       m_data);
        chk("has_data",   {63'd0, has_data},   {63'd0, m_has});
        chk("rd_valid",   {63'd0, rd_valid},   {63'd0, m_rv});
        chk("credit_ret", {63'd0, credit_ret}, {63'd0, m_cr});
        chk("empty",      {63'd0, empty},      {63'd0, mq.size() == 0});
        chk("full",       {63'd0, full},       {63'd0, mq.size() == DEPTH});
        chk("count",      {58'd0, count},      64'(mq.size()));
        chk("overflow",   {63'd0, overflow},   {63'd0, m_ovf});
    endtask

    // Apply one cycle of inputs, advance the model with pre-edge state, then compare.
    task automatic step(input logic v, input logic [63:0] w, input logic fl, input logic rd);
        bit   was_full, was_empty, have_pkt;
        pkt_t p, o;
        deser_valid = v; deser_data = w; flush = fl; read_enable = rd;
        @(posedge clk);
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        m_cr = m_rv;
        if (fl) begin
            mq.delete(); m_pend = 0; m_ovf = 0; m_rv = 0;
        end else begin
            m_rv = 0;
            if (rd && !was_empty) begin
                o = mq.pop_front();
                m_hdr = o.h; m_data = o.d; m_has = o.hd; m_rv = 1;
            end
            have_pkt = 0;
            if (v) begin
                if (m_pend) begin
                    p.h = m_phdr; p.d = w; p.hd = 1; have_pkt = 1; m_pend = 0;
                end else if (is_data_op(w[4:0])) begin
                    m_phdr = w; m_pend = 1;
                end else begin
                    p.h = w; p.d = '0; p.hd = 0; have_pkt = 1;
                end
            end
            if (have_pkt) begin
                if (was_full) m_ovf = 1;
                else mq.push_back(p);
            end
        end
        #1;
        deser_valid = 0; flush = 0; read_enable = 0;
        compare_all();
    endtask

    initial begin
        logic [63:0] w;
        rst_n = 0; deser_valid = 0; deser_data = '0; flush = 0; read_enable = 0;
        model_reset();
        #12;
        chk("reset_empty", {63'd0, empty}, 64'd1);
        chk("reset_count", {58'd0, count}, 64'd0);
        compare_all();
        @(negedge clk) rst_n = 1;

        // Header-only completion then read
        step(1, 64'hA5A5_0000_1234_0010, 0, 0);
        step(0, '0, 0, 1);
        chk("t1_rd_valid", {63'd0, rd_valid}, 64'd1);
        chk("t1_has_data", {63'd0, has_data}, 64'd0);
        chk("t1_data",     data, 64'd0);
        chk("t1_hdr",      hdr,  64'hA5A5_0000_1234_0010);
        step(0, '0, 0, 0);
        chk("t1_credit", {63'd0, credit_ret}, 64'd1);

        // Data-carrying opcode 01001
        step(1, 64'h1111_2222_3333_4409, 0, 0);
        step(1, 64'hDEAD_BEEF_0123_4567, 0, 0);
        step(0, '0, 0, 1);
        chk("t2_has_data", {63'd0, has_data}, 64'd1);
        chk("t2_data",     data, 64'hDEAD_BEEF_0123_4567);
        chk("t2_hdr",      hdr,  64'h1111_2222_3333_4409);

        // Fill to full, overflow, simultaneous commit+read when full, drain
        for (int i = 0; i < DEPTH; i++) step(1, {32'hC0DE_0000 + 32'(i), 32'h0000_0010}, 0, 0);
        chk("t3_full",  {63'd0, full}, 64'd1);
        chk("t3_count", {58'd0, count}, 64'd32);
        step(1, 64'hBAD0_0000_0000_0010, 0, 0);
        chk("t3_overflow", {63'd0, overflow}, 64'd1);
        chk("t3_count33",  {58'd0, count}, 64'd32);
        step(1, 64'hBAD1_0000_0000_0010, 0, 1);
        chk("t3_full_rdwr_count", {58'd0, count}, 64'd31);
        chk("t3_first_out", hdr, 64'hC0DE_0000_0000_0010);
        for (int i = 0; i < DEPTH - 1; i++) step(0, '0, 0, 1);
        chk("t3_last_out", hdr, 64'hC0DE_001F_0000_0010);
        chk("t3_empty", {63'd0, empty}, 64'd1);

        // Empty FIFO: commit and read together
        step(1, 64'h0E0E_0000_0000_0012, 0, 1);
        chk("t4_no_rdvalid", {63'd0, rd_valid}, 64'd0);
        chk("t4_count",      {58'd0, count}, 64'd1);

        // Flush mid-packet (overflow still sticky from above)
        step(1, 64'h7777_0000_0000_001B, 0, 0);
        step(0, '0, 1, 0);
        chk("t5_empty",    {63'd0, empty}, 64'd1);
        chk("t5_overflow", {63'd0, overflow}, 64'd0);
        step(1, 64'h5555_0000_0000_0004, 0, 0);
        chk("t5_hdr_count", {58'd0, count}, 64'd1);
        step(0, '0, 0, 1);
        chk("t5_has_data", {63'd0, has_data}, 64'd0);
        chk("t5_hdr",      hdr, 64'h5555_0000_0000_0004);

        // Three fill/drain rounds across pointer wrap, mixed packet kinds
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i % 2 == 0) begin
                    step(1, {16'hF00D, 8'(r), 8'(i), 32'h0000_0002}, 0, 0);
                end else begin
                    step(1, {16'hF00D, 8'(r), 8'(i), 32'h0000_0001}, 0, 0);
                    step(1, {32'h0DA7_A000 + 32'(i), 24'd0, 8'(r)}, 0, 0);
                end
            end
            chk("t6_full", {63'd0, full}, 64'd1);
            for (int i = 0; i < DEPTH; i++) step(0, '0, 0, 1);
            chk("t6_last_data", data, {32'h0DA7_A01F, 24'd0, 8'(r)});
        end

        // Asynchronous reset while in ST_DATA with outputs non-zero
        step(1, 64'h9999_0000_0000_0003, 0, 0);
        step(1, 64'h8888_0000_0000_0003, 0, 0);
        step(1, 64'h1234_5678_9ABC_DEF0, 0, 0);
        step(1, 64'h4444_0000_0000_0019, 0, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_hdr",      hdr,  64'd0);
        chk("rst_data",     data, 64'd0);
        chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("rst_empty",    {63'd0, empty}, 64'd1);
        chk("rst_count",    {58'd0, count}, 64'd0);
        model_reset();
        compare_all();
        @(negedge clk) rst_n = 1;
        w = 64'h6666_0000_0000_0010;
        step(1, w, 0, 0);
        step(0, '0, 0, 1);
        chk("post_rst_hdr", hdr, 64'h6666_0000_0000_0010);
        chk("post_rst_has", {63'd0, has_data}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
